// File: rtl/traffic_mode_ctrl.sv
// traffic_mode_ctrl: supervises the two-lane light sequencer, switching between auto, manual-step and night-flash modes with all-red clearance
module traffic_mode_ctrl #(
   parameter int DEF_GREEN  = 20,
   parameter int DEF_YELLOW = 3,
   parameter int ALLRED_CYC = 2,
   parameter int FLASH_HALF = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cfg_wr,
   input  logic [6:0] cfg_green,
   input  logic [6:0] cfg_yellow,
   input  logic [6:0] cfg_red,
   output logic       cfg_ack,
   output logic       cfg_err,
   input  logic       manual_req,
   input  logic       manual_step,
   input  logic       night_req,
   input  logic [2:0] auto_state,
   input  logic [6:0] auto_t1,
   input  logic [6:0] auto_t2,
   output logic       auto_enable,
   output logic [6:0] greenTime,
   output logic [6:0] yellowTime,
   output logic [6:0] redTime,
   output logic [2:0] lamp1,
   output logic [2:0] lamp2,
   output logic [2:0] mode
);
   localparam logic [2:0] S_INIT   = 3'd0;
   localparam logic [2:0] S_ALLRED = 3'd1;
   localparam logic [2:0] S_AUTO   = 3'd2;
   localparam logic [2:0] S_DRAIN  = 3'd3;
   localparam logic [2:0] S_MANUAL = 3'd4;
   localparam logic [2:0] S_NIGHT  = 3'd5;
   localparam logic [1:0] P_GR     = 2'd0;
   localparam logic [7:0] CLR_LOAD = 8'(ALLRED_CYC - 1);
   localparam logic [7:0] FL_HALF  = 8'(FLASH_HALF);
   localparam logic [7:0] FL_LAST  = 8'(2 * FLASH_HALF - 1);
   localparam logic [6:0] D_GREEN  = 7'(DEF_GREEN);
   localparam logic [6:0] D_YELLOW = 7'(DEF_YELLOW);
   localparam logic [6:0] D_RED    = 7'(DEF_GREEN + DEF_YELLOW);

   logic [2:0] state, target, eff_target;
   logic [7:0] clr_cnt, fl_cnt;
   logic [1:0] phase;
   logic [6:0] pend_g, pend_y, pend_r;
   logic       pending_valid, cfg_ok, cfg_take, to_auto, safe_pt, leaving_clr;
   logic       unused_t1;

   assign unused_t1   = ^auto_t1;
   assign cfg_ok      = |cfg_green && |cfg_yellow && ({1'b0, cfg_green} + {1'b0, cfg_yellow} == {1'b0, cfg_red});
   assign cfg_take    = cfg_wr && cfg_ok;
   assign eff_target  = (state == S_ALLRED) ? target : S_AUTO;
   assign leaving_clr = (state == S_ALLRED || state == S_INIT) && clr_cnt == 8'd0;
   assign to_auto     = leaving_clr && eff_target == S_AUTO;
   assign safe_pt     = auto_state == 3'd6 && auto_t2 == 7'd0;
   assign mode        = state;

   // lamp decode for a sequencer-style state code {lamp1, lamp2}
   function automatic logic [5:0] dec(input logic [2:0] s);
      return s == 3'd3 ? 6'b001_100 :
             s == 3'd4 ? 6'b010_100 :
             s == 3'd5 ? 6'b100_001 :
             s == 3'd6 ? 6'b100_010 : 6'b100_100;
   endfunction

   // validate timing writes; accepted writes go to the pending set
   always_ff @(posedge clk) begin
      if (reset) begin
         cfg_ack       <= 1'b0;
         cfg_err       <= 1'b0;
         pending_valid <= 1'b0;
         pend_g        <= D_GREEN;
         pend_y        <= D_YELLOW;
         pend_r        <= D_RED;
      end else begin
         cfg_ack <= cfg_take;
         cfg_err <= cfg_wr && !cfg_ok;
         if (cfg_take) begin
            pend_g        <= cfg_green;
            pend_y        <= cfg_yellow;
            pend_r        <= cfg_red;
            pending_valid <= 1'b1;
         end else if (to_auto) begin
            pending_valid <= 1'b0;
         end
      end
   end

   // active timing only changes on the edge that re-enables the sequencer
   always_ff @(posedge clk) begin
      if (reset) begin
         greenTime  <= D_GREEN;
         yellowTime <= D_YELLOW;
         redTime    <= D_RED;
      end else if (to_auto && pending_valid) begin
         greenTime  <= pend_g;
         yellowTime <= pend_y;
         redTime    <= pend_r;
      end
   end

   // sequencer enable: on when clearance hands over to auto, off at the drain safe point
   always_ff @(posedge clk) begin
      if (reset)
         auto_enable <= 1'b0;
      else if (to_auto)
         auto_enable <= 1'b1;
      else if (state == S_DRAIN && safe_pt)
         auto_enable <= 1'b0;
   end

   // mode state machine with clearance counter, manual phase and flash counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_ALLRED;
         target  <= S_AUTO;
         clr_cnt <= CLR_LOAD;
         phase   <= P_GR;
         fl_cnt  <= 8'd0;
      end else begin
         case (state)
            S_INIT, S_ALLRED: begin
               if (leaving_clr) begin
                  state  <= eff_target;
                  phase  <= P_GR;
                  fl_cnt <= 8'd0;
               end else begin
                  clr_cnt <= clr_cnt - 8'd1;
               end
            end
            S_AUTO: begin
               if (night_req || manual_req || pending_valid) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (safe_pt) begin
                  state   <= S_ALLRED;
                  clr_cnt <= CLR_LOAD;
                  target  <= night_req ? S_NIGHT : manual_req ? S_MANUAL : S_AUTO;
               end
            end
            S_MANUAL: begin
               if ((night_req || !manual_req) && !phase[0]) begin
                  state   <= S_ALLRED;
                  clr_cnt <= CLR_LOAD;
                  target  <= night_req ? S_NIGHT : S_AUTO;
               end else if (manual_step) begin
                  phase <= phase + 2'd1;
               end
            end
            S_NIGHT: begin
               fl_cnt <= (fl_cnt == FL_LAST) ? 8'd0 : fl_cnt + 8'd1;
               if (!night_req) begin
                  state   <= S_ALLRED;
                  clr_cnt <= CLR_LOAD;
                  target  <= manual_req ? S_MANUAL : S_AUTO;
               end
            end
            default: begin
               state   <= S_ALLRED;
               clr_cnt <= CLR_LOAD;
               target  <= S_AUTO;
            end
         endcase
      end
   end

   // final lamp drive for both lanes
   always_comb begin
      {lamp1, lamp2} = (state == S_AUTO || state == S_DRAIN) ? dec(auto_state) :
                       (state == S_MANUAL) ? dec({1'b0, phase} + 3'd3) :
                       (state == S_NIGHT) ? ((fl_cnt < FL_HALF) ? 6'b010_010 : 6'b000_000) :
                       6'b100_100;
   end
endmodule

// File: tb/tb_traffic_mode_ctrl.sv
// tb_traffic_mode_ctrl: table-driven check of mode arbitration, timing updates and lamp drive
module tb_traffic_mode_ctrl;
   localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

   typedef struct packed {
      logic       rst, wr;
      logic [6:0] g, y, r;
      logic       man, stp, ngt;
      logic [2:0] ast;
      logic [6:0] t2;
   } in_t;

   typedef struct packed {
      logic [2:0] mode;
      logic       en, ack, err;
      logic [2:0] l1, l2;
      logic [6:0] gt, yt, rt;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset, cfg_wr, manual_req, manual_step, night_req;
   logic [6:0] cfg_green, cfg_yellow, cfg_red, auto_t1, auto_t2;
   logic [2:0] auto_state;
   logic       cfg_ack, cfg_err, auto_enable;
   logic [6:0] greenTime, yellowTime, redTime;
   logic [2:0] lamp1, lamp2, mode;

   int errors = 0;
   int checks = 0;
   vec_t tbl[$];

   traffic_mode_ctrl dut (
      .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_green(cfg_green),
      .cfg_yellow(cfg_yellow), .cfg_red(cfg_red), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
      .manual_req(manual_req), .manual_step(manual_step), .night_req(night_req),
      .auto_state(auto_state), .auto_t1(auto_t1), .auto_t2(auto_t2),
      .auto_enable(auto_enable), .greenTime(greenTime), .yellowTime(yellowTime),
      .redTime(redTime), .lamp1(lamp1), .lamp2(lamp2), .mode(mode)
   );

   always #5 clk = ~clk;

   function automatic vec_t v(input logic rst, wr, input logic [6:0] g, y, r,
                              input logic man, stp, ngt, input logic [2:0] ast, input logic [6:0] t2,
                              input logic [2:0] md, input logic en, ack, err,
                              input logic [2:0] l1, l2, input logic [6:0] gt, yt, rt);
      vec_t x;
      x.i = '{rst, wr, g, y, r, man, stp, ngt, ast, t2};
      x.o = '{md, en, ack, err, l1, l2, gt, yt, rt};
      return x;
   endfunction

   task automatic run(input string name, input vec_t x);
      out_t a;
      reset = x.i.rst; cfg_wr = x.i.wr; cfg_green = x.i.g; cfg_yellow = x.i.y; cfg_red = x.i.r;
      manual_req = x.i.man; manual_step = x.i.stp; night_req = x.i.ngt;
      auto_state = x.i.ast; auto_t2 = x.i.t2; auto_t1 = x.i.t2;
      @(posedge clk);
      #1;
      a = '{mode, auto_enable, cfg_ack, cfg_err, lamp1, lamp2, greenTime, yellowTime, redTime};
      checks++;
      if (a !== x.o) begin
         errors++;
         $display("FAIL %s: got mode=%0d en=%b ack=%b err=%b l1=%b l2=%b t=%0d/%0d/%0d, want mode=%0d en=%b ack=%b err=%b l1=%b l2=%b t=%0d/%0d/%0d",
                  name, a.mode, a.en, a.ack, a.err, a.l1, a.l2, a.gt, a.yt, a.rt,
                  x.o.mode, x.o.en, x.o.ack, x.o.err, x.o.l1, x.o.l2, x.o.gt, x.o.yt, x.o.rt);
      end
   endtask

   initial begin
      // reset release, default timing, auto entry
      tbl.push_back(v(1,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 20,3,23));
      // rejected writes
      tbl.push_back(v(0,1, 10,2,13, 0,0,0, 3,5, 2,1,0,1, G,R, 20,3,23));
      tbl.push_back(v(0,1, 0,3,3,   0,0,0, 3,5, 2,1,0,1, G,R, 20,3,23));
      tbl.push_back(v(0,1, 120,10,2,0,0,0, 3,5, 2,1,0,1, G,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 4,5, 2,1,0,0, Y,R, 20,3,23));
      // accepted write drains and applies
      tbl.push_back(v(0,1, 10,2,12, 0,0,0, 5,5, 2,1,1,0, R,G, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 6,3, 3,1,0,0, R,Y, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 6,1, 3,1,0,0, R,Y, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 6,0, 1,0,0,0, R,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 20,3,23));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 10,2,12));
      // manual mode
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 3,1,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 6,0, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 4,0,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,1,0, 3,5, 4,0,0,0, Y,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,1,0, 3,5, 4,0,0,0, R,G, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,1,0, 3,5, 4,0,0,0, R,Y, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 4,0,0,0, R,Y, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 4,0,0,0, R,Y, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,1,0, 3,5, 4,0,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 10,2,12));
      // night flash, manual ignored, release into manual
      tbl.push_back(v(0,0, 0,0,0,   0,0,1, 3,5, 3,1,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,1, 6,0, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,1, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,1, 3,5, 5,0,0,0, Y,Y, 10,2,12));
      for (int k = 0; k < 3; k++) tbl.push_back(v(0,0, 0,0,0, 1,0,1, 3,5, 5,0,0,0, Y,Y, 10,2,12));
      for (int k = 0; k < 4; k++) tbl.push_back(v(0,0, 0,0,0, 1,0,1, 3,5, 5,0,0,0, O,O, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,1, 3,5, 5,0,0,0, Y,Y, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   1,0,0, 3,5, 4,0,0,0, G,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      tbl.push_back(v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 10,2,12));

      foreach (tbl[n]) run($sformatf("vec%0d", n), tbl[n]);

      // write accepted in the exact clearance-to-auto cycle, then reset mid-drain
      run("old_pend_wr",   v(0,1, 8,2,10,  0,0,0, 3,5, 2,1,1,0, G,R, 10,2,12));
      run("old_pend_drn",  v(0,0, 0,0,0,   0,0,0, 6,0, 3,1,0,0, R,Y, 10,2,12));
      run("old_pend_safe", v(0,0, 0,0,0,   0,0,0, 6,0, 1,0,0,0, R,R, 10,2,12));
      run("old_pend_clr",  v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 10,2,12));
      run("edge_wr_apply", v(0,1, 10,2,12, 0,0,0, 3,5, 2,1,1,0, G,R, 8,2,10));
      run("edge_wr_drain", v(0,0, 0,0,0,   0,0,0, 3,5, 3,1,0,0, G,R, 8,2,10));
      run("mid_rst",       v(1,0, 0,0,0,   0,0,0, 6,5, 1,0,0,0, R,R, 20,3,23));
      run("rst_clr1",      v(0,0, 0,0,0,   0,0,0, 3,5, 1,0,0,0, R,R, 20,3,23));
      run("rst_auto",      v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 20,3,23));
      run("rst_no_pend",   v(0,0, 0,0,0,   0,0,0, 3,5, 2,1,0,0, G,R, 20,3,23));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
